// File: rtl/decoder_pkg.sv
// Shared encodings for the registered N-to-2**N decoder: load modes and FSM states.
package decoder_pkg;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    STROBE = 2'd2,
    SCAN   = 2'd3
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with an enable gate.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [(1<<SEL_W)-1:0] onehot_o
);

  for (genvar gi = 0; gi < (1 << SEL_W); gi++) begin : g_bit
    assign onehot_o[gi] = en_i && (sel_i == SEL_W'(gi));
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2**N decoder with LEVEL / PULSE / SCAN modes and a valid/ready select load.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  output logic [(1<<SEL_W)-1:0] d,
  output logic                  busy,
  output logic                  wrap
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

  if (SEL_W < 1 || SEL_W > 6 || SCAN_DIV < 1) begin : g_param_check
    $error("decoder_nto2n_seq: SEL_W must be 1..6 and SCAN_DIV >= 1");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] index_q, index_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] d_q, d_d;
  logic             dec_en;
  logic             accept;

  assign sel_ready = !rst && !clr && (state_q != STROBE);
  assign accept    = sel_valid && sel_ready;

  // The next index is decoded, so d always reflects the state entered at this edge.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel_i    (index_d),
    .en_i     (dec_en),
    .onehot_o (d_d)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    div_d   = div_q;
    wrap_d  = 1'b0;
    dec_en  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      div_d   = '0;
    end else if (accept) begin
      div_d = '0;
      case (mode)
        MODE_LEVEL: begin state_d = HOLD;   index_d = sel; dec_en = enable; end
        MODE_PULSE: begin state_d = STROBE; index_d = sel; dec_en = enable; end
        MODE_SCAN:  begin state_d = SCAN;   index_d = sel; dec_en = enable; end
        default:    state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE:   state_d = IDLE;
        HOLD:   dec_en = enable;
        STROBE: state_d = IDLE;
        SCAN: begin
          // With enable low the dwell position freezes and the output is gated off.
          if (enable) begin
            dec_en = 1'b1;
            if (div_q == DIV_LAST) begin
              div_d   = '0;
              index_d = index_q + SEL_W'(1);
              wrap_d  = (index_q == IDX_LAST);
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      div_q   <= '0;
      wrap_q  <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      div_q   <= div_d;
      wrap_q  <= wrap_d;
      d_q     <= d_d;
    end
  end

  assign d    = d_q;
  assign wrap = wrap_q;
  assign busy = (state_q != IDLE);

endmodule
